pc_gen: RTL



---
 rtl/pc_gen_pkg.sv | 19 +
 rtl/pc_gen_if.sv | 25 ++
 rtl/pc_gen_redir_arbiter.sv | 30 +++
 rtl/pc_gen.sv | 84 ++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared configuration and state encodings for the fetch-stage PC generator.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package pc_gen_pkg;

    localparam int unsigned DEFAULT_ADDR_W       = `DATA_WIDTH;
    localparam int unsigned DEFAULT_RESET_VECTOR = 0;
    localparam int unsigned DEFAULT_INSN_BYTES   = 4;
    localparam int unsigned DEFAULT_NUM_REDIR    = 2;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pc_gen_if.sv
// Stall/redirect requests into the PC generator and the fetch address it produces.
interface pc_gen_if
    import pc_gen_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEFAULT_ADDR_W,
    parameter int unsigned NUM_REDIR = DEFAULT_NUM_REDIR
);
    logic                          stall;
    logic [NUM_REDIR-1:0]          redir_valid;
    logic [NUM_REDIR*ADDR_W-1:0]   redir_addr;
    logic [ADDR_W-1:0]             PC;
    logic                          pc_valid;
    logic [ADDR_W-1:0]             npc;
    logic                          redir_pending;

    modport master (
        output stall, redir_valid, redir_addr,
        input  PC, pc_valid, npc, redir_pending
    );

    modport slave (
        input  stall, redir_valid, redir_addr,
        output PC, pc_valid, npc, redir_pending
    );
endinterface

// File: rtl/pc_gen_redir_arbiter.sv
// Fixed-priority redirect select: lowest valid channel wins, target aligned to INSN_BYTES.
module redir_arbiter
    import pc_gen_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEFAULT_ADDR_W,
    parameter int unsigned INSN_BYTES = DEFAULT_INSN_BYTES,
    parameter int unsigned NUM_REDIR  = DEFAULT_NUM_REDIR
) (
    input  logic [NUM_REDIR-1:0]        valid_i,
    input  logic [NUM_REDIR*ADDR_W-1:0] addr_i,
    output logic                        any_valid_o,
    output logic [ADDR_W-1:0]           target_o
);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INSN_BYTES - 1);

    logic [ADDR_W-1:0] sel_addr;

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        any_valid_o = 1'b0;
        sel_addr    = '0;
        for (int i = NUM_REDIR - 1; i >= 0; i--) begin
            if (valid_i[i]) begin
                any_valid_o = 1'b1;
                sel_addr    = addr_i[i*ADDR_W +: ADDR_W];
            end
        end
        target_o = sel_addr & ~ALIGN_MASK;
    end
endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter with prioritised redirects and a stall-time redirect buffer.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned       ADDR_W       = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR),
    parameter int unsigned       INSN_BYTES   = DEFAULT_INSN_BYTES,
    parameter int unsigned       NUM_REDIR    = DEFAULT_NUM_REDIR
) (
    input  logic     CLK,
    input  logic     RST_N,
    pc_gen_if.slave  bus
);
    localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(INSN_BYTES);

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_q, pend_d;
    logic              pc_valid_q, pc_valid_d;
    logic              any_valid;
    logic [ADDR_W-1:0] target;

    redir_arbiter #(
        .ADDR_W     (ADDR_W),
        .INSN_BYTES (INSN_BYTES),
        .NUM_REDIR  (NUM_REDIR)
    ) u_arb (
        .valid_i     (bus.redir_valid),
        .addr_i      (bus.redir_addr),
        .any_valid_o (any_valid),
        .target_o    (target)
    );

    // Next-state and next-PC selection.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        pc_valid_d = pc_valid_q;
        unique case (state_q)
            BOOT: begin
                pc_d       = any_valid ? target : RESET_VECTOR;
                pc_valid_d = 1'b1;
                state_d    = RUN;
            end
            RUN: begin
                if (!bus.stall) begin
                    pc_d = any_valid ? target : pc_q + PC_INC;
                end else if (any_valid) begin
                    pend_d  = target;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (bus.stall) begin
                    if (any_valid) pend_d = target;
                end else begin
                    pc_d    = any_valid ? target : pend_q;
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            pend_q     <= '0;
            pc_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pc_valid_q <= pc_valid_d;
        end
    end

    assign bus.PC            = pc_q;
    assign bus.pc_valid      = pc_valid_q;
    assign bus.npc           = pc_q + PC_INC;
    assign bus.redir_pending = (state_q == PEND);
endmodule
